// File: rtl/lsu_pkg.sv
// Shared widths, DataMemory direction encoding and the store-buffer entry
// layout for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int RD_W     = 5;
    localparam int SB_DEPTH = 4;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/load_store_unit_store_buffer.sv
// Circular FIFO of pending stores with a combinational address lookup that
// returns the youngest matching entry for store-to-load forwarding.
module store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    output sb_entry_t         head_entry,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] idx;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = entries[head];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[tail] <= push_entry;
    end

    // Walk oldest-to-youngest so the last match found is the youngest store.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage front end: accepts loads/stores, buffers stores and drains them
// in order, forwards buffered data to loads, returns load results after 1 cycle.
module load_store_unit #(
    parameter int ADDR_W   = lsu_pkg::ADDR_W,
    parameter int DATA_W   = lsu_pkg::DATA_W,
    parameter int RD_W     = lsu_pkg::RD_W,
    parameter int SB_DEPTH = lsu_pkg::SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    // req_valid/req_ready: an op transfers on a cycle where both are high;
    // a held request must keep its fields stable until it transfers.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic [RD_W-1:0]   ld_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              sb_empty
);

    lsu_pkg::sb_entry_t push_entry;
    lsu_pkg::sb_entry_t head_entry;
    logic               sb_full;
    logic               sb_is_empty;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;
    logic               accept;
    logic               ld_accept;
    logic               ld_miss;
    logic               drain;

    assign req_ready  = !sb_full;
    assign accept     = req_valid && req_ready;
    assign ld_accept  = accept && !req_is_store;
    assign ld_miss    = ld_accept && !hit;
    // A missing load owns the port; forwarded loads leave it free for a drain.
    assign drain      = !rst && !ld_miss && !sb_is_empty;
    assign push_entry = '{addr: req_addr, data: req_wdata};
    assign sb_empty   = sb_is_empty;

    store_buffer #(
        .DEPTH(SB_DEPTH)
    ) u_store_buffer (
        .clk         (clk),
        .rst         (rst),
        .push        (accept && req_is_store),
        .push_entry  (push_entry),
        .pop         (drain),
        .head_entry  (head_entry),
        .full        (sb_full),
        .empty       (sb_is_empty),
        .lookup_addr (req_addr),
        .lookup_hit  (hit),
        .lookup_data (hit_data)
    );

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_read_write = lsu_pkg::MEM_READ;
        if (ld_miss) begin
            mem_address = req_addr;
        end else if (drain) begin
            mem_address    = head_entry.addr;
            mem_write_data = head_entry.data;
            mem_read_write = lsu_pkg::MEM_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_rd    <= '0;
        end else begin
            ld_valid <= ld_accept;
            if (ld_accept) begin
                ld_data <= hit ? hit_data : mem_read_data;
                ld_rd   <= req_rd;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_load_store_unit;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RW = 5;
    localparam int SBD = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [RW-1:0] req_rd;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic [RW-1:0] ld_rd;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_write;
    logic [DW-1:0] mem_read_data;
    logic          sb_empty;

    int checks = 0;
    int failures = 0;

    load_store_unit #(
        .ADDR_W(AW), .DATA_W(DW), .RD_W(RW), .SB_DEPTH(SBD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_rd          (ld_rd),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_write (mem_read_write),
        .mem_read_data  (mem_read_data),
        .sb_empty       (sb_empty)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory stand-in: synchronous write, combinational read.
    logic [DW-1:0] tb_mem [256];
    initial for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    always @(posedge clk) if (mem_read_write === 1'b1) tb_mem[mem_address] = mem_write_data;
    assign mem_read_data = tb_mem[mem_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [AW+DW-1:0] sb_q[$];     // pending stores {addr,data}, oldest first
    logic [DW+RW-1:0] exp_q[$];    // load results {data,rd} awaiting return
    logic [DW-1:0]    ref_mem [256];
    bit               model_on = 0;
    bit               prev_rst = 0;
    bit               exp_ldv = 0;
    bit               m_ready, m_load, m_hit, m_drain;
    logic [DW-1:0]    m_hd;
    logic [AW+DW-1:0] m_head;
    logic [DW+RW-1:0] m_res;

    initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_rw", mem_read_write, 0);
            if (prev_rst) begin
                chk("rst_ld_valid", ld_valid, 0);
                chk("rst_sb_empty", sb_empty, 1);
            end
            sb_q.delete();
            exp_q.delete();
            exp_ldv = 0;
            model_on = 1;
            prev_rst = 1;
        end else if (model_on) begin
            if (prev_rst) begin
                chk("post_rst_ld_data", ld_data, 0);
                chk("post_rst_ld_rd", ld_rd, 0);
            end
            prev_rst = 0;
            chk("ld_valid", ld_valid, exp_ldv);
            if (exp_ldv && exp_q.size() > 0) begin
                m_res = exp_q.pop_front();
                chk("ld_data", ld_data, m_res[DW+RW-1:RW]);
                chk("ld_rd", ld_rd, m_res[RW-1:0]);
            end
            chk("sb_empty", sb_empty, sb_q.size() == 0);
            m_ready = sb_q.size() < SBD;
            chk("req_ready", req_ready, m_ready);
            m_load = req_valid && m_ready && !req_is_store;
            m_hit = 0;
            m_hd = '0;
            foreach (sb_q[i]) begin
                if (sb_q[i][AW+DW-1:DW] == req_addr) begin
                    m_hit = 1;
                    m_hd = sb_q[i][DW-1:0];
                end
            end
            m_drain = 0;
            if (m_load && !m_hit) begin
                chk("port_read_rw", mem_read_write, 0);
                chk("port_read_addr", mem_address, req_addr);
            end else if (sb_q.size() > 0) begin
                m_drain = 1;
                m_head = sb_q[0];
                chk("port_drain_rw", mem_read_write, 1);
                chk("port_drain_addr", mem_address, m_head[AW+DW-1:DW]);
                chk("port_drain_data", mem_write_data, m_head[DW-1:0]);
            end else begin
                chk("port_idle_rw", mem_read_write, 0);
                chk("port_idle_addr", mem_address, 0);
                chk("port_idle_data", mem_write_data, 0);
            end
            if (m_load) exp_q.push_back({m_hit ? m_hd : ref_mem[req_addr], req_rd});
            exp_ldv = m_load;
            if (m_drain) begin
                ref_mem[m_head[AW+DW-1:DW]] = m_head[DW-1:0];
                void'(sb_q.pop_front());
            end
            if (req_valid && m_ready && req_is_store) sb_q.push_back({req_addr, req_wdata});
        end
    end

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [RW-1:0] rd);
        int waited = 0;
        req_valid = 1; req_is_store = st; req_addr = a; req_wdata = d; req_rd = rd;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 50) begin
                chk("issue_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic load_check(input logic [AW-1:0] a, input logic [RW-1:0] rd,
                              input logic [DW-1:0] exp_d, input logic exp_rw,
                              input logic [AW-1:0] exp_addr);
        req_valid = 1; req_is_store = 0; req_addr = a; req_rd = rd;
        @(negedge clk);
        chk("dir_ready", req_ready, 1);
        chk("dir_rw", mem_read_write, exp_rw);
        chk("dir_addr", mem_address, exp_addr);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk("dir_ld_valid", ld_valid, 1);
        chk("dir_ld_data", ld_data, exp_d);
        chk("dir_ld_rd", ld_rd, rd);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    bit took;

    initial begin
        rst = 1; req_valid = 0; req_is_store = 0; req_addr = '0; req_wdata = '0; req_rd = '0;
        idle(3);
        rst = 0;

        // In-order drain of four stores.
        issue(1, 8'd1, 8'h11, '0);
        issue(1, 8'd2, 8'h22, '0);
        issue(1, 8'd3, 8'h33, '0);
        issue(1, 8'd4, 8'h44, '0);
        @(negedge clk);
        chk("dir_sb_busy", sb_empty, 0);
        @(posedge clk); #1;
        idle(3);
        chk("dir_mem1", tb_mem[1], 8'h11);
        chk("dir_mem2", tb_mem[2], 8'h22);
        chk("dir_mem3", tb_mem[3], 8'h33);
        chk("dir_mem4", tb_mem[4], 8'h44);
        @(negedge clk);
        chk("dir_sb_drained", sb_empty, 1);
        @(posedge clk); #1;

        // Forward from the head while it drains.
        issue(1, 8'd5, 8'hA5, '0);
        load_check(8'd5, 5'd17, 8'hA5, 1'b1, 8'd5);
        idle(2);

        // Youngest match wins.
        issue(1, 8'd7, 8'h01, '0);
        issue(1, 8'd7, 8'h02, '0);
        load_check(8'd7, 5'd9, 8'h02, 1'b1, 8'd7);
        idle(2);

        // Stores interleaved with unrelated loads of addr 9.
        for (int i = 0; i < 4; i++) begin
            issue(1, AW'(10 + i), DW'(8'hB0 + i), '0);
            issue(0, 8'd9, '0, RW'(i));
        end
        idle(3);

        // Miss goes to memory while a store waits behind it.
        issue(1, 8'd3, 8'h3C, '0);
        idle(2);
        issue(1, 8'd6, 8'h66, '0);
        load_check(8'd3, 5'd21, 8'h3C, 1'b0, 8'd3);
        idle(3);

        // Reset discards a pending store before it reaches memory.
        issue(1, 8'd8, 8'h88, '0);
        rst = 1;
        @(negedge clk);
        chk("dir_rst_no_write", mem_read_write, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("dir_rst_sb_empty", sb_empty, 1);
        chk("dir_rst_ld_valid", ld_valid, 0);
        @(posedge clk); #1;
        idle(3);
        chk("dir_rst_mem8", tb_mem[8], 8'h00);

        // Randomized traffic, model-checked every cycle.
        took = 1;
        for (int c = 0; c < 2500; c++) begin
            if (!req_valid || took) begin
                req_valid    = ($urandom_range(0, 9) < 7);
                req_is_store = 1'($urandom_range(0, 1));
                req_addr     = AW'($urandom_range(0, 15));
                req_wdata    = DW'($urandom);
                req_rd       = RW'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            took = (req_valid && req_ready) || rst;
            @(posedge clk); #1;
        end
        rst = 0;
        req_valid = 0;
        idle(8);
        chk("end_sb_empty", sb_empty, 1);
        chk("end_exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
